// File: rtl/csr_arbiter.sv
// csr_arbiter: round-robin two-master arbiter for the shared CSR bus; optional keep-grant locking via CSR_ARB_LOCK_EN
module csr_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_a,
  input  logic [DATA_WIDTH-1:0] m0_do,
  input  logic                  m0_lock,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_di,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_a,
  input  logic [DATA_WIDTH-1:0] m1_do,
  input  logic                  m1_lock,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_di,
  output logic [ADDR_WIDTH-1:0] csr_a,
  output logic [DATA_WIDTH-1:0] csr_do,
  output logic                  csr_we,
  input  logic [DATA_WIDTH-1:0] csr_di
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t r_state, w_next;
  logic r_last, r_sel;
  logic w_e0, w_e1, w_grant, w_gsel, w_gwe, w_locked, w_lock_m;
`ifdef CSR_ARB_LOCK_EN
  logic r_lock, r_lock_m;
  assign w_lock_m = r_lock_m;
  assign w_locked = r_lock && (r_lock_m ? (m1_req && m1_lock) : (m0_req && m0_lock));
  // lock is re-armed from the owner's lock bit as each access finishes and released once the owner lets go in IDLE
  always_ff @(posedge clk)
    if (rst) begin
      r_lock   <= 1'b0;
      r_lock_m <= 1'b0;
    end else if (r_state == DATA) begin
      r_lock   <= r_sel ? m1_lock : m0_lock;
      r_lock_m <= r_sel;
    end else if (r_state == IDLE && !w_locked) begin
      r_lock   <= 1'b0;
    end
`else
  logic w_unused_lock;
  assign w_unused_lock = m0_lock ^ m1_lock;
  assign w_lock_m = 1'b0;
  assign w_locked = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // eligibility (a master being acked sits out one cycle), round-robin pick and next state
  always_comb begin
    w_e0    = m0_req && !m0_ack && !(w_locked && w_lock_m);
    w_e1    = m1_req && !m1_ack && !(w_locked && !w_lock_m);
    w_grant = (r_state == IDLE) && (w_e0 || w_e1);
    w_gsel  = (w_e0 && w_e1) ? !r_last : w_e1;
    w_gwe   = w_gsel ? m1_we : m0_we;
    w_next  = (r_state == IDLE) ? (w_grant ? ADDR : IDLE) : ((r_state == ADDR) ? DATA : IDLE);
  end
  // registered bus drive, one-cycle write strobe in ADDR, read capture and ack at the end of DATA
  always_ff @(posedge clk)
    if (rst) begin
      csr_a  <= '0;
      csr_do <= '0;
      csr_we <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_di  <= '0;
      m1_di  <= '0;
      r_last <= 1'b1;
      r_sel  <= 1'b0;
    end else begin
      csr_we <= w_grant && w_gwe;
      m0_ack <= (r_state == DATA) && !r_sel;
      m1_ack <= (r_state == DATA) && r_sel;
      if (w_grant) begin
        csr_a  <= w_gsel ? m1_a : m0_a;
        csr_do <= w_gsel ? m1_do : m0_do;
        r_sel  <= w_gsel;
      end
      if (r_state == DATA) begin
        if (r_sel) m1_di <= csr_di;
        else       m0_di <= csr_di;
        r_last <= r_sel;
      end
    end
endmodule

// File: tb/tb_csr_arbiter.sv
// tb_csr_arbiter: directed and randomized checks of csr_arbiter against a transaction-level model
module tb_csr_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [AW-1:0] m0_a = '0, m1_a = '0;
  logic [DW-1:0] m0_do = '0, m1_do = '0;
  logic m0_ack, m1_ack, csr_we;
  logic [DW-1:0] m0_di, m1_di, csr_do, csr_di;
  logic [AW-1:0] csr_a;
  logic mem_init = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_do(m0_do), .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_di(m0_di),
    .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_do(m1_do), .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_di(m1_di),
    .csr_a(csr_a), .csr_do(csr_do), .csr_we(csr_we), .csr_di(csr_di)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'h5A ^ 8'(i) ^ 8'h0C;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  logic [DW-1:0] pm [32];
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 32; i++) pm[i] <= init_val(i);
    else if (csr_we) pm[csr_a] <= csr_do;
    csr_di <= pm[csr_a];
  end

  logic [DW-1:0] rm [32];
  int ph = 0;
  logic mvalid = 0, wasrst = 0, msel = 0, mwe = 0, dwe = 0, mlast = 1, mlock = 0, mlock_m = 0;
  logic [AW-1:0] ea = '0;
  logic [DW-1:0] edo = '0, edi = '0;
  logic ewe = 0;
  logic [1:0] eack = '0, nack;
  logic e0, e1;
  always @(negedge clk) begin
    if (mem_init) for (int i = 0; i < 32; i++) rm[i] = init_val(i);
    if (mvalid) begin
      chk("csr_a", csr_a, ea);
      chk("csr_do", csr_do, edo);
      chk("csr_we", csr_we, ewe);
      chk("m0_ack", m0_ack, eack[0]);
      chk("m1_ack", m1_ack, eack[1]);
      chk("one_ack", m0_ack & m1_ack, 0);
      if (eack[0] && !dwe) chk("m0_di", m0_di, edi);
      if (eack[1] && !dwe) chk("m1_di", m1_di, edi);
      if (wasrst) begin
        chk("rst_m0_di", m0_di, 0);
        chk("rst_m1_di", m1_di, 0);
      end
    end
    if (ph == 1 && ewe) rm[ea] = edo;
    nack = '0;
    if (rst) begin
      ph = 0; ea = '0; edo = '0; ewe = 0; eack = '0; mlast = 1; mlock = 0; wasrst = 1; mvalid = 1;
    end else begin
      wasrst = 0;
      if (ph == 0) begin
        if (mlock && !(mlock_m ? (m1_req && m1_lock) : (m0_req && m0_lock))) mlock = 0;
        e0 = m0_req && !eack[0] && !(mlock && mlock_m);
        e1 = m1_req && !eack[1] && !(mlock && !mlock_m);
        if (e0 || e1) begin
          msel = (e0 && e1) ? !mlast : e1;
          ea = msel ? m1_a : m0_a;
          edo = msel ? m1_do : m0_do;
          ewe = msel ? m1_we : m0_we;
          mwe = ewe;
          ph = 1;
        end
      end else if (ph == 1) begin
        ewe = 0;
        ph = 2;
      end else begin
        nack[msel] = 1'b1;
        edi = rm[ea];
        dwe = mwe;
        mlast = msel;
`ifdef CSR_ARB_LOCK_EN
        mlock = msel ? m1_lock : m0_lock;
        mlock_m = msel;
`endif
        ph = 0;
      end
      eack = nack;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  int order [6];
  int n, m1n, first;
  initial begin
    repeat (3) cyc;
    chk("rst_csr_a", csr_a, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_di", m1_di, 0);
    rst = 0; mem_init = 0;
    cyc;
    m0_req = 1; m0_we = 1; m0_a = 5'h10; m0_do = 8'hA5;
    cyc;
    chk("t1_we", csr_we, 1);
    chk("t1_a", csr_a, 5'h10);
    chk("t1_do", csr_do, 8'hA5);
    cyc;
    chk("t1_we_off", csr_we, 0);
    chk("t1_early_ack", m0_ack, 0);
    cyc;
    chk("t1_ack", m0_ack, 1);
    m0_req = 0; m0_we = 0;
    cyc;
    chk("t1_ack_off", m0_ack, 0);
    m1_req = 1; m1_we = 0; m1_a = 5'h0C;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("t2_we", csr_we, 0);
    end
    chk("t2_ack", m1_ack, 1);
    chk("t2_di", m1_di, 8'h5A);
    m1_req = 0;
    cyc;
    for (int i = 0; i < 6; i++) order[i] = 9;
    m0_req = 1; m1_req = 1; m0_a = 5'h01; m1_a = 5'h02;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      cyc;
      if (m0_ack || m1_ack) begin
        order[n] = m1_ack ? 1 : 0;
        n++;
        if (n == 6) begin m0_req = 0; m1_req = 0; end
      end
    end
    m0_req = 0; m1_req = 0;
    chk("t3_count", n, 6);
    for (int i = 0; i < 6; i++) chk("t3_order", order[i], i % 2);
    cyc;
    m1_req = 1; m1_a = 5'h0C;
    cyc;
    cyc;
    rst = 1; m1_req = 0;
    cyc;
    chk("t4_m1_ack", m1_ack, 0);
    chk("t4_csr_a", csr_a, 0);
    chk("t4_csr_do", csr_do, 0);
    chk("t4_csr_we", csr_we, 0);
    chk("t4_m0_di", m0_di, 0);
    rst = 0;
    m0_req = 1; m1_req = 1;
    first = 9;
    for (int c = 0; c < 10 && first == 9; c++) begin
      cyc;
      if (m0_ack || m1_ack) begin
        first = m1_ack ? 1 : 0;
        m0_req = 0; m1_req = 0;
      end
    end
    m0_req = 0; m1_req = 0;
    chk("t4_first", first, 0);
    cyc;
    for (int i = 0; i < 6; i++) order[i] = 9;
    m0_req = 1; m1_req = 1; m1_lock = 1;
    n = 0; m1n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      cyc;
      if (m0_ack || m1_ack) begin
        order[n] = m1_ack ? 1 : 0;
        n++;
        if (m1_ack) m1n++;
        if (m1n == 3) begin m1_req = 0; m1_lock = 0; end
        if (n == 4) begin m0_req = 0; m1_req = 0; m1_lock = 0; end
      end
    end
    m0_req = 0; m1_req = 0; m1_lock = 0;
    chk("t5_count", n, 4);
`ifdef CSR_ARB_LOCK_EN
    chk("t5_order0", order[0], 1);
    chk("t5_order1", order[1], 1);
    chk("t5_order2", order[2], 1);
    chk("t5_order3", order[3], 0);
`else
    chk("t5_order0", order[0], 1);
    chk("t5_order1", order[1], 0);
    chk("t5_order2", order[2], 1);
    chk("t5_order3", order[3], 0);
`endif
    cyc;
    for (int c = 0; c < 3000; c++) begin
      cyc;
      rst = ($urandom_range(0, 199) == 0);
      if (m0_req && m0_ack) begin
        if ($urandom_range(0, 1) == 0) m0_req = 0;
        else begin m0_we = 1'($urandom); m0_a = 5'($urandom_range(0, 7)); m0_do = 8'($urandom); end
      end else if (!m0_req && $urandom_range(0, 2) == 0) begin
        m0_req = 1; m0_we = 1'($urandom); m0_a = 5'($urandom_range(0, 7)); m0_do = 8'($urandom);
      end
      if (m1_req && m1_ack) begin
        if ($urandom_range(0, 1) == 0) m1_req = 0;
        else begin m1_we = 1'($urandom); m1_a = 5'($urandom_range(0, 7)); m1_do = 8'($urandom); end
      end else if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1; m1_we = 1'($urandom); m1_a = 5'($urandom_range(0, 7)); m1_do = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0) m0_lock = ~m0_lock;
      if ($urandom_range(0, 3) == 0) m1_lock = ~m1_lock;
    end
    rst = 0; m0_req = 0; m1_req = 0;
    repeat (6) cyc;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_arbiter.md
Name: csr_arbiter

Overview:
- Shares the single internal CSR bus (csr_a/csr_di/csr_we/csr_do) between two masters: m0 is the I2C slave, m1 is an internal agent such as a power/boot sequencer.
- Uses a round-robin grant, a fixed 3-cycle access sequence, and a registered req/ack handshake per master.
- Sits between the masters and the OR-combined peripheral read bus. Peripherals are unchanged and see one registered master.

Parameters:
ADDR_WIDTH, 5, CSR address width
DATA_WIDTH, 8, CSR data width

Ports:
clk  in  1  system clock; one clock for the whole block
rst  in  1  synchronous, active-high reset
m0_req  in  1  m0 access request; held until m0_ack
m0_we  in  1  m0 write (1) / read (0)
m0_a  in  ADDR_WIDTH  m0 address
m0_do  in  DATA_WIDTH  m0 write data
m0_lock  in  1  m0 keep-grant request (used only with CSR_ARB_LOCK_EN)
m0_ack  out  1  one-cycle completion strobe
m0_di  out  DATA_WIDTH  m0 read data, valid while m0_ack=1
m1_req, m1_we, m1_a, m1_do, m1_lock, m1_ack, m1_di  same as m0_* for master 1
csr_a  out  ADDR_WIDTH  bus address (registered)
csr_do  out  DATA_WIDTH  bus write data (registered)
csr_we  out  1  bus write strobe (registered, one cycle)
csr_di  in  DATA_WIDTH  OR-combined peripheral read data; valid one cycle after csr_a is presented

Behaviour:
- Reset values:
  - csr_a=0, csr_do=0, csr_we=0
  - m0_ack=m1_ack=0, m0_di=m1_di=0
  - state=IDLE, last_grant=1, so m0 wins first.
- State IDLE:
  - Eligible master = req=1 and its ack is not high this cycle. A master whose ack is high is ignored for that cycle.
  - Only one eligible: grant it.
  - Both eligible: grant the master that is not last_grant.
  - On grant: register the master's a/do into csr_a/csr_do, record sel and we, go to ADDR.
- State ADDR:
  - csr_a and csr_do stable.
  - csr_we=1 this cycle only, and only if the latched we=1.
  - Go to DATA.
- State DATA:
  - csr_a held and csr_we=0.
  - At the end of the cycle, capture csr_di into the selected master's m*_di (also on writes, value don't-care).
  - Set that master's m*_ack=1 for the next cycle.
  - last_grant<=sel; go to IDLE.
- Latency: req seen in IDLE at cycle k → ADDR k+1 → DATA k+2 → ack/di visible k+3. Back-to-back accesses take 4 cycles each.
- Masters drop req or present a new request in the ack cycle. A new access is granted no earlier than the cycle after ack.
- After an access:
  - csr_a keeps its last value in IDLE.
  - csr_we is never high outside ADDR.
  - Only one ack is high in any cycle.
- req withdrawn after grant: the access completes and ack is still issued.
- rst in any state: return to IDLE with all outputs at reset values next cycle. An interrupted access is dropped with no ack. A write whose ADDR cycle has already passed stays committed.
- Fairness: with both req held continuously, grants alternate m0, m1, m0, …

Optional Feature:
- Macro CSR_ARB_LOCK_EN.
- Defined:
  - If the selected master has lock=1 at the end of DATA, the arbiter enters locked mode.
  - In IDLE only that master is eligible. The other master waits indefinitely.
  - Locked mode ends when the locked master is in IDLE with req=0 or lock=0.
  - last_grant is updated normally; rst clears the lock.
- Not defined: m*_lock are ignored and arbitration is pure round-robin.

Test Plan:
- After rst, m0 write a=0x10 do=0xA5 → csr_we=1 for exactly 1 cycle, with csr_a=0x10 and csr_do=0xA5 in that cycle; m0_ack pulses 3 cycles after the req sample.
- m1 read a=0x0C with model csr_di registered from csr_a, returning 0x5A → m1_di=0x5A together with m1_ack; csr_we stays 0 throughout.
- m0 and m1 req together and held for 6 accesses → grant order m0, m1, m0, m1, m0, m1; never two acks in one cycle.
- rst asserted in the DATA cycle of an m1 read → no m1_ack, all outputs 0 the next cycle; m0 then wins the first grant.
- CSR_ARB_LOCK_EN defined, m1 lock=1 over 3 accesses while m0 req is held → m1 served 3 times, then m0 served after m1 drops lock. Without the macro → m0 and m1 alternate.
